calibration_multi: RTL and testbench

- Parametrised successor to the four-zone calibration block.
- Tracks up to NUM_MARKERS bright blobs in one raster frame and computes each blob's bounding box.
- When the host requests it, runs a sequential min/max pass over blob centres to produce the calibrated screen extents xo/xf/yo/yf.
- Sits between the bright-pixel detector (is_bright, hcount, vcount) and the coordinate-mapping logic.

---
 rtl/calibration_multi_if.sv | 39 +++
 rtl/calibration_multi.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_calibration_multi.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calibration_multi_if.sv
// calibration_multi_if
// Bundles the pixel stream, the host handshake and the calibration results
// of calibration_multi into one interface.
//   master modport (host / pixel source): drives hcount, vcount, is_bright,
//     start; observes busy, done, valid, overflow, marker_count,
//     xo_r, xf_r, yo_r, yf_r.
//   slave modport (calibration_multi): the mirror image.
// Parameters must match the ones given to calibration_multi.
interface calibration_multi_if #(
  parameter int NUM_MARKERS = 4,
  parameter int HW          = 11,
  parameter int VW          = 11
);
  localparam int CW = $clog2(NUM_MARKERS + 1);

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          is_bright;
  logic          start;
  logic          busy;
  logic          done;
  logic          valid;
  logic          overflow;
  logic [CW-1:0] marker_count;
  logic [HW-1:0] xo_r;
  logic [HW-1:0] xf_r;
  logic [VW-1:0] yo_r;
  logic [VW-1:0] yf_r;

  modport master (
    output hcount, vcount, is_bright, start,
    input  busy, done, valid, overflow, marker_count, xo_r, xf_r, yo_r, yf_r
  );

  modport slave (
    input  hcount, vcount, is_bright, start,
    output busy, done, valid, overflow, marker_count, xo_r, xf_r, yo_r, yf_r
  );
endinterface

// File: rtl/calibration_multi.sv
// calibration_multi
// Tracks up to NUM_MARKERS bright blobs in one raster frame, keeps a bounding
// box per blob, then on host request reduces the blob centres to the
// calibrated screen extents xo_r/xf_r (x min/max) and yo_r/yf_r (y min/max).
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-low reset
//   bus    calibration_multi_if.slave: hcount/vcount/is_bright pixel stream,
//          start request, busy/done/valid/overflow/marker_count status and
//          the four extent registers.
// Optional build macro CAL_AVG_EN: averages the extents over 2^AVG_LOG2
// consecutive frames; without it a single frame is captured.
module calibration_multi #(
  parameter int NUM_MARKERS = 4,
  parameter int HW          = 11,
  parameter int VW          = 11,
  parameter int MINH        = 50,
  parameter int MAXH        = 740,
  parameter int MINV        = 75,
  parameter int MAXV        = 550,
  parameter int MERGE_DIST  = 4,
  parameter int AVG_LOG2    = 2
) (
  input logic              clk,
  input logic              reset,
  calibration_multi_if.slave bus
);
  localparam int CW  = $clog2(NUM_MARKERS + 1);
  localparam int IW  = (NUM_MARKERS > 1) ? $clog2(NUM_MARKERS) : 1;
  localparam int HW1 = HW + 1;
  localparam int VW1 = VW + 1;

  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_MARKERS - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(NUM_MARKERS);
  localparam logic [HW-1:0]  MIN_H    = HW'(MINH);
  localparam logic [HW-1:0]  MAX_H    = HW'(MAXH);
  localparam logic [VW-1:0]  MIN_V    = VW'(MINV);
  localparam logic [VW-1:0]  MAX_V    = VW'(MAXV);
  localparam logic [HW1-1:0] MD_H     = HW1'(MERGE_DIST);
  localparam logic [VW1-1:0] MD_V     = VW1'(MERGE_DIST);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARM     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] REDUCE  = 3'd3;
  localparam logic [2:0] RESULT  = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] idx;

  logic [NUM_MARKERS-1:0] used;
  logic [HW-1:0] t_left   [NUM_MARKERS];
  logic [HW-1:0] t_right  [NUM_MARKERS];
  logic [VW-1:0] t_top    [NUM_MARKERS];
  logic [VW-1:0] t_bottom [NUM_MARKERS];
  logic          ovf_flag;

  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] min_x, max_x, min_x_n, max_x_n;
  logic [VW-1:0] min_y, max_y, min_y_n, max_y_n;

  logic          done_r, valid_r, ovf_r;
  logic [CW-1:0] count_r;
  logic [HW-1:0] xo, xf;
  logic [VW-1:0] yo, yf;

  logic fb, in_window, clear_trk, last_idx;

  assign fb        = (bus.hcount == '0) && (bus.vcount == '0);
  assign in_window = bus.is_bright &&
                     (bus.hcount > MIN_H) && (bus.hcount < MAX_H) &&
                     (bus.vcount > MIN_V) && (bus.vcount < MAX_V);
  assign last_idx  = (idx == LAST_IDX);

`ifdef CAL_AVG_EN
  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'((1 << AVG_LOG2) - 1);
  logic [FW-1:0]          fcnt;
  logic                   all_ok;
  logic [HW+AVG_LOG2-1:0] acc_xo, acc_xf;
  logic [VW+AVG_LOG2-1:0] acc_yo, acc_yf;
  // Trackers restart at the first fb and again after every intermediate
  // frame's reduction; the next frame's fb was already consumed by REDUCE.
  assign clear_trk = (state == ARM && fb) ||
                     (state == REDUCE && last_idx && fcnt != LAST_FRAME);
`else
  assign clear_trk = (state == ARM && fb);
`endif

  // hcount >= left-MERGE_DIST is tested as hcount+MERGE_DIST >= left, which
  // is the saturating form without a subtraction; one extra bit avoids wrap.
  logic [NUM_MARKERS-1:0] match;
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_MARKERS; i++) begin
      match[i] = used[i] &&
                 ({1'b0, bus.hcount} + MD_H >= {1'b0, t_left[i]}) &&
                 ({1'b0, bus.hcount} <= {1'b0, t_right[i]} + MD_H) &&
                 ({1'b0, bus.vcount} <= {1'b0, t_bottom[i]} + MD_V);
    end
  end

  // Descending scan so the lowest matching / lowest free tracker wins.
  logic          hit, free;
  logic [IW-1:0] hit_idx, free_idx;
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_MARKERS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!used[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Blob trackers. Raster is top-down, so a matched pixel always becomes the
  // new bottom and the top never moves after allocation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      used     <= '0;
      ovf_flag <= 1'b0;
    end else if (clear_trk) begin
      used     <= '0;
      ovf_flag <= 1'b0;
    end else if (state == CAPTURE && !fb && in_window) begin
      if (hit) begin
        if (bus.hcount < t_left[hit_idx])  t_left[hit_idx]  <= bus.hcount;
        if (bus.hcount > t_right[hit_idx]) t_right[hit_idx] <= bus.hcount;
        t_bottom[hit_idx] <= bus.vcount;
      end else if (free) begin
        used[free_idx]     <= 1'b1;
        t_left[free_idx]   <= bus.hcount;
        t_right[free_idx]  <= bus.hcount;
        t_top[free_idx]    <= bus.vcount;
        t_bottom[free_idx] <= bus.vcount;
      end else begin
        ovf_flag <= 1'b1;
      end
    end
  end

  // Centre of the tracker under reduction and the updated running min/max.
  logic [HW:0]   sum_x;
  logic [VW:0]   sum_y;
  logic [HW-1:0] cx;
  logic [VW-1:0] cy;
  always_comb begin
    sum_x   = {1'b0, t_left[idx]} + {1'b0, t_right[idx]};
    sum_y   = {1'b0, t_top[idx]} + {1'b0, t_bottom[idx]};
    cx      = HW'(sum_x >> 1);
    cy      = VW'(sum_y >> 1);
    min_x_n = min_x;
    max_x_n = max_x;
    min_y_n = min_y;
    max_y_n = max_y;
    cnt_n   = cnt;
    if (used[idx]) begin
      if (cx < min_x) min_x_n = cx;
      if (cx > max_x) max_x_n = cx;
      if (cy < min_y) min_y_n = cy;
      if (cy > max_y) max_y_n = cy;
      cnt_n = cnt + CW'(1);
    end
  end

  // Control FSM plus the registered result/status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      min_x   <= '0;
      max_x   <= '0;
      min_y   <= '0;
      max_y   <= '0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
      count_r <= '0;
      xo      <= '0;
      xf      <= '0;
      yo      <= '0;
      yf      <= '0;
`ifdef CAL_AVG_EN
      fcnt    <= '0;
      all_ok  <= 1'b0;
      acc_xo  <= '0;
      acc_xf  <= '0;
      acc_yo  <= '0;
      acc_yf  <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) state <= ARM;
        ARM: begin
          if (fb) begin
            state <= CAPTURE;
`ifdef CAL_AVG_EN
            fcnt   <= '0;
            all_ok <= 1'b1;
            acc_xo <= '0;
            acc_xf <= '0;
            acc_yo <= '0;
            acc_yf <= '0;
`endif
          end
        end
        CAPTURE: begin
          if (fb) begin
            state <= REDUCE;
            idx   <= '0;
            cnt   <= '0;
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
          end
        end
        REDUCE: begin
          cnt   <= cnt_n;
          min_x <= min_x_n;
          max_x <= max_x_n;
          min_y <= min_y_n;
          max_y <= max_y_n;
          idx   <= idx + IW'(1);
          if (last_idx) begin
`ifdef CAL_AVG_EN
            acc_xo <= acc_xo + (HW+AVG_LOG2)'(min_x_n);
            acc_xf <= acc_xf + (HW+AVG_LOG2)'(max_x_n);
            acc_yo <= acc_yo + (VW+AVG_LOG2)'(min_y_n);
            acc_yf <= acc_yf + (VW+AVG_LOG2)'(max_y_n);
            all_ok <= all_ok && (cnt_n == FULL_CNT) && !ovf_flag;
            fcnt   <= fcnt + FW'(1);
            state  <= (fcnt == LAST_FRAME) ? RESULT : CAPTURE;
`else
            state <= RESULT;
`endif
          end
        end
        RESULT: begin
          done_r  <= 1'b1;
          count_r <= cnt;
          ovf_r   <= ovf_flag;
`ifdef CAL_AVG_EN
          valid_r <= all_ok;
          if (all_ok) begin
            xo <= HW'(acc_xo >> AVG_LOG2);
            xf <= HW'(acc_xf >> AVG_LOG2);
            yo <= VW'(acc_yo >> AVG_LOG2);
            yf <= VW'(acc_yf >> AVG_LOG2);
          end
`else
          valid_r <= (cnt == FULL_CNT) && !ovf_flag;
          if ((cnt == FULL_CNT) && !ovf_flag) begin
            xo <= min_x;
            xf <= max_x;
            yo <= min_y;
            yf <= max_y;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_r;
  assign bus.valid        = valid_r;
  assign bus.overflow     = ovf_r;
  assign bus.marker_count = count_r;
  assign bus.xo_r         = xo;
  assign bus.xf_r         = xf;
  assign bus.yo_r         = yo;
  assign bus.yf_r         = yf;
endmodule

// File: tb/tb_calibration_multi.sv
// tb_calibration_multi
// Directed bench for calibration_multi in its default (single-frame) build.
// Pixels are presented sparsely: a frame is the fb pixel (0,0), the bright
// pixels in raster order, then the fb pixel that closes the capture.
module tb_calibration_multi;
  logic clk;
  logic reset;
  int checks;
  int errors;

  int sq_x [8];
  int sq_y [8];
  int n_sq;

  calibration_multi_if #(.NUM_MARKERS(4), .HW(11), .VW(11)) bus ();

  calibration_multi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one pixel for one clock; returns 1 ns after the edge.
  task automatic pixel(input int h, input int v, input logic b);
    bus.hcount    = 11'(h);
    bus.vcount    = 11'(v);
    bus.is_bright = b;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_capture();
    bus.start = 1'b1;
    pixel(5, 5, 1'b0);
    bus.start = 1'b0;
    pixel(0, 0, 1'b0);
  endtask

  task automatic send_squares();
    for (int v = 0; v < 600; v++)
      for (int k = 0; k < n_sq; k++)
        if (v >= sq_y[k] - 2 && v <= sq_y[k] + 2)
          for (int h = sq_x[k] - 2; h <= sq_x[k] + 2; h++)
            pixel(h, v, 1'b1);
  endtask

  // Closing fb, then count edges until done; -1 means it never came.
  task automatic end_capture(output int lat);
    lat = -1;
    pixel(0, 0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      pixel(1, 0, 1'b0);
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic set_four();
    sq_x[0] = 100; sq_y[0] = 100;
    sq_x[1] = 600; sq_y[1] = 100;
    sq_x[2] = 100; sq_y[2] = 500;
    sq_x[3] = 600; sq_y[3] = 500;
    n_sq = 4;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pixel(5, 5, 1'b0);
    pixel(5, 5, 1'b0);
    reset = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: busy=%b done=%b valid=%b overflow=%b, required all 0",
               bus.busy, bus.done, bus.valid, bus.overflow);
    end
    checks++;
    if (bus.marker_count !== 3'd0 || bus.xo_r !== 11'd0 || bus.xf_r !== 11'd0 ||
        bus.yo_r !== 11'd0 || bus.yf_r !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: count=%0d xo=%0d xf=%0d yo=%0d yf=%0d, required all 0",
               bus.marker_count, bus.xo_r, bus.xf_r, bus.yo_r, bus.yf_r);
    end
  endtask

  task automatic test_four_markers();
    int lat;
    set_four();
    bus.start = 1'b1;
    pixel(5, 5, 1'b0);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b, required 1", bus.busy);
    end
    pixel(0, 0, 1'b0);
    send_squares();
    end_capture(lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("[TB] FAIL done_latency: got %0d, required 5", lat);
    end
    checks++;
    if (bus.xo_r !== 11'd100 || bus.xf_r !== 11'd600 || bus.yo_r !== 11'd100 || bus.yf_r !== 11'd500) begin
      errors++;
      $display("[TB] FAIL four_extents: xo=%0d xf=%0d yo=%0d yf=%0d, required 100 600 100 500",
               bus.xo_r, bus.xf_r, bus.yo_r, bus.yf_r);
    end
    checks++;
    if (bus.valid !== 1'b1 || bus.marker_count !== 3'd4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL four_status: valid=%b count=%0d overflow=%b, required 1 4 0",
               bus.valid, bus.marker_count, bus.overflow);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_after_done: got %b, required 0", bus.busy);
    end
    pixel(1, 0, 1'b0);
    checks++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_pulse: done=%b valid=%b, required 0 1", bus.done, bus.valid);
    end
  endtask

  task automatic test_three_markers();
    int lat;
    set_four();
    n_sq = 3;
    begin_capture();
    send_squares();
    end_capture(lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("[TB] FAIL three_latency: got %0d, required 5", lat);
    end
    checks++;
    if (bus.valid !== 1'b0 || bus.marker_count !== 3'd3 || bus.overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL three_status: valid=%b count=%0d overflow=%b, required 0 3 0",
               bus.valid, bus.marker_count, bus.overflow);
    end
    checks++;
    if (bus.xo_r !== 11'd100 || bus.xf_r !== 11'd600 || bus.yo_r !== 11'd100 || bus.yf_r !== 11'd500) begin
      errors++;
      $display("[TB] FAIL three_hold: xo=%0d xf=%0d yo=%0d yf=%0d, required 100 600 100 500",
               bus.xo_r, bus.xf_r, bus.yo_r, bus.yf_r);
    end
  endtask

  task automatic test_overflow();
    int lat;
    sq_x[0] = 100; sq_y[0] = 100;
    sq_x[1] = 600; sq_y[1] = 100;
    sq_x[2] = 350; sq_y[2] = 300;
    sq_x[3] = 100; sq_y[3] = 500;
    sq_x[4] = 600; sq_y[4] = 500;
    n_sq = 5;
    begin_capture();
    send_squares();
    end_capture(lat);
    checks++;
    if (lat != 5 || bus.overflow !== 1'b1 || bus.valid !== 1'b0 || bus.marker_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL overflow_status: lat=%0d overflow=%b valid=%b count=%0d, required 5 1 0 4",
               lat, bus.overflow, bus.valid, bus.marker_count);
    end
    checks++;
    if (bus.xo_r !== 11'd100 || bus.xf_r !== 11'd600 || bus.yo_r !== 11'd100 || bus.yf_r !== 11'd500) begin
      errors++;
      $display("[TB] FAIL overflow_hold: xo=%0d xf=%0d yo=%0d yf=%0d, required 100 600 100 500",
               bus.xo_r, bus.xf_r, bus.yo_r, bus.yf_r);
    end
  endtask

  // Blob with a 2-column gap (203,204) plus bright pixels on or outside the
  // window edges; only the blob may be counted.
  task automatic test_merge_window();
    int lat;
    begin_capture();
    pixel(300, 75, 1'b1);
    for (int v = 200; v <= 202; v++) begin
      for (int h = 200; h <= 202; h++) pixel(h, v, 1'b1);
      for (int h = 205; h <= 207; h++) pixel(h, v, 1'b1);
    end
    pixel(40, 300, 1'b1);
    pixel(50, 300, 1'b1);
    pixel(740, 400, 1'b1);
    pixel(300, 550, 1'b1);
    pixel(300, 560, 1'b1);
    end_capture(lat);
    checks++;
    if (lat != 5 || bus.marker_count !== 3'd1 || bus.overflow !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL merge_window: lat=%0d count=%0d overflow=%b valid=%b, required 5 1 0 0",
               lat, bus.marker_count, bus.overflow, bus.valid);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    set_four();
    begin_capture();
    for (int h = 98; h <= 102; h++) pixel(h, 98, 1'b1);
    reset = 1'b0;
    pixel(99, 99, 1'b1);
    reset = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.marker_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midreset_status: busy=%b done=%b valid=%b overflow=%b count=%0d, required all 0",
               bus.busy, bus.done, bus.valid, bus.overflow, bus.marker_count);
    end
    checks++;
    if (bus.xo_r !== 11'd0 || bus.xf_r !== 11'd0 || bus.yo_r !== 11'd0 || bus.yf_r !== 11'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: xo=%0d xf=%0d yo=%0d yf=%0d, required all 0",
               bus.xo_r, bus.xf_r, bus.yo_r, bus.yf_r);
    end
    begin_capture();
    send_squares();
    end_capture(lat);
    checks++;
    if (lat != 5 || bus.valid !== 1'b1 || bus.marker_count !== 3'd4 ||
        bus.xo_r !== 11'd100 || bus.xf_r !== 11'd600 || bus.yo_r !== 11'd100 || bus.yf_r !== 11'd500) begin
      errors++;
      $display("[TB] FAIL rerun_after_reset: lat=%0d valid=%b count=%0d xo=%0d xf=%0d yo=%0d yf=%0d, required 5 1 4 100 600 100 500",
               lat, bus.valid, bus.marker_count, bus.xo_r, bus.xf_r, bus.yo_r, bus.yf_r);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.hcount    = 11'd5;
    bus.vcount    = 11'd5;
    bus.is_bright = 1'b0;
    test_reset();
    test_four_markers();
    test_three_markers();
    test_overflow();
    test_merge_window();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
